// File: rtl/uio_byte_tx_if.sv
// Signal bundle between the core / far end and uio_byte_tx.
// bus_par is present only when UIO_TX_PARITY_EN is defined.
interface uio_byte_tx_if;
  // Write side: a byte moves on a clock edge where wr_valid && wr_ready; wr_data must hold while
  // wr_valid is high and not accepted. Bus side: 4-phase, stb rises after data settles, ack answers,
  // stb falls, ack falls, then the bus is released.
  logic [7:0] wr_data;
  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] bus_data;
  logic [7:0] bus_oe;
  logic       bus_stb;
  logic       bus_ack;
  logic       busy;
  logic       timeout;
`ifdef UIO_TX_PARITY_EN
  logic       bus_par;

  modport master (
    input  wr_data, wr_valid, bus_ack,
    output wr_ready, bus_data, bus_oe, bus_stb, busy, timeout, bus_par
  );
  modport slave (
    output wr_data, wr_valid, bus_ack,
    input  wr_ready, bus_data, bus_oe, bus_stb, busy, timeout, bus_par
  );
`else
  modport master (
    input  wr_data, wr_valid, bus_ack,
    output wr_ready, bus_data, bus_oe, bus_stb, busy, timeout
  );
  modport slave (
    output wr_data, wr_valid, bus_ack,
    input  wr_ready, bus_data, bus_oe, bus_stb, busy, timeout
  );
`endif
endinterface

// File: rtl/uio_byte_tx.sv
// Byte transmitter for the bidirectional uio bus: small FIFO plus a strobe/ack sender that
// tri-states the pins between bytes. Define UIO_TX_PARITY_EN to add the bus_par even-parity output.
module uio_byte_tx #(
  parameter int DEPTH     = 4,
  parameter int SETUP_CYC = 1,
  parameter int TIMEOUT   = 255
) (
  input  logic              clk,
  input  logic              rst,
  uio_byte_tx_if.master     bus,
  output logic [1:0]        dbg_state_o
);
  localparam int AW      = $clog2(DEPTH);
  localparam int CNT_MAX = (TIMEOUT > SETUP_CYC) ? TIMEOUT : SETUP_CYC;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] SU_LAST = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    STROBE  = 2'd2,
    RELEASE = 2'd3
  } state_t;

  logic [7:0]    mem_q [DEPTH];
  logic [AW:0]   wptr_q, rptr_q;
  logic          full, empty, push, pop;
  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [7:0]    data_q, oe_q;
  logic          stb_q, to_q;
  logic          to_hit;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  // No bypass: a full FIFO refuses the write even when the head is popped the same cycle.
  assign push  = bus.wr_valid && !full;
  assign pop   = (state_q == IDLE) && !empty && !bus.bus_ack;
  assign to_hit = (TIMEOUT != 0) && (cnt_q == TO_LAST);

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q[AW-1:0]] <= bus.wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      oe_q    <= '0;
      stb_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      to_q  <= 1'b0;
      cnt_q <= cnt_q + CW'(1);
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (pop) begin
            data_q  <= mem_q[rptr_q[AW-1:0]];
            oe_q    <= 8'hFF;
            state_q <= SETUP;
          end
        end
        SETUP: begin
          if (cnt_q == SU_LAST) begin
            stb_q   <= 1'b1;
            cnt_q   <= '0;
            state_q <= STROBE;
          end
        end
        STROBE: begin
          if (bus.bus_ack) begin
            stb_q   <= 1'b0;
            cnt_q   <= '0;
            state_q <= RELEASE;
          end else if (to_hit) begin
            stb_q   <= 1'b0;
            oe_q    <= '0;
            data_q  <= '0;
            to_q    <= 1'b1;
            state_q <= IDLE;
          end
        end
        RELEASE: begin
          // A timeout here drops the bus the same way as a stuck-low ack in STROBE.
          if (!bus.bus_ack || to_hit) begin
            oe_q    <= '0;
            data_q  <= '0;
            to_q    <= !bus.bus_ack ? 1'b0 : 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.wr_ready = !full;
  assign bus.bus_data = data_q;
  assign bus.bus_oe   = oe_q;
  assign bus.bus_stb  = stb_q;
  assign bus.busy     = (state_q != IDLE) || !empty;
  assign bus.timeout  = to_q;
  assign dbg_state_o  = state_q;

`ifdef UIO_TX_PARITY_EN
  // data_q is cleared whenever the bus is released, so parity reads 0 while idle.
  assign bus.bus_par = ^data_q;
`endif
endmodule

// File: tb/tb_uio_byte_tx.sv
// Directed bench for uio_byte_tx: write-side driver, far-end ack responder and a byte scoreboard.
// Define UIO_TX_PARITY_EN to also exercise bus_par.
module tb_uio_byte_tx;
  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] dbg_state;
  int         n_checks = 0;
  int         n_fail = 0;
  logic [7:0] exp_q[$];

  uio_byte_tx_if bus_if();

  uio_byte_tx #(.DEPTH(4), .SETUP_CYC(1), .TIMEOUT(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus_if),
    .dbg_state_o (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic wait_stb(input logic val, input int limit, input string tag);
    int k = 0;
    while (bus_if.bus_stb !== val && k < limit) begin
      @(negedge clk);
      k++;
    end
    chk1(tag, bus_if.bus_stb, val);
  endtask

  task automatic write_byte(input logic [7:0] d, input bit push_exp);
    int k = 0;
    bus_if.wr_data  = d;
    bus_if.wr_valid = 1'b1;
    while (bus_if.wr_ready !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk1("wr_accept", bus_if.wr_ready, 1'b1);
    @(negedge clk);
    if (push_exp) exp_q.push_back(d);
  endtask

  // Far-end responder for one byte: scoreboard check, delayed ack, delayed release.
  task automatic respond(input int ack_dly, input int rel_dly);
    logic [7:0] e;
    int k;
    wait_stb(1'b1, 40, "stb_rise");
    chk1("exp_avail", exp_q.size() > 0, 1'b1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
    chk8("data_at_stb", bus_if.bus_data, e);
    chk8("oe_at_stb", bus_if.bus_oe, 8'hFF);
`ifdef UIO_TX_PARITY_EN
    chk1("par_at_stb", bus_if.bus_par, ^e);
`endif
    repeat (ack_dly) begin
      @(negedge clk);
      chk8("data_hold", bus_if.bus_data, e);
    end
    bus_if.bus_ack = 1'b1;
    wait_stb(1'b0, 4, "stb_fall");
    chk8("data_after_ack", bus_if.bus_data, e);
    repeat (rel_dly) @(negedge clk);
    chk8("oe_in_release", bus_if.bus_oe, 8'hFF);
    bus_if.bus_ack = 1'b0;
    k = 0;
    while (bus_if.bus_oe !== 8'h00 && k < 4) begin
      @(negedge clk);
      k++;
    end
    chk8("oe_released", bus_if.bus_oe, 8'h00);
    chk8("data_released", bus_if.bus_data, 8'h00);
`ifdef UIO_TX_PARITY_EN
    chk1("par_released", bus_if.bus_par, 1'b0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=time_limit expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst             = 1'b1;
    bus_if.wr_data  = 8'h00;
    bus_if.wr_valid = 1'b0;
    bus_if.bus_ack  = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    chk8("rst_oe", bus_if.bus_oe, 8'h00);
    chk8("rst_data", bus_if.bus_data, 8'h00);
    chk1("rst_stb", bus_if.bus_stb, 1'b0);
    chk1("rst_wr_ready", bus_if.wr_ready, 1'b1);
    chk1("rst_busy", bus_if.busy, 1'b0);
    chk1("rst_timeout", bus_if.timeout, 1'b0);

    // Single byte 3C: latency and hold timing with a 2-cycle ack delay
    write_byte(8'h3C, 1'b1);
    bus_if.wr_valid = 1'b0;
    chk1("lat_stb_c1", bus_if.bus_stb, 1'b0);
    chk8("lat_oe_c1", bus_if.bus_oe, 8'h00);
    @(negedge clk);
    chk1("lat_stb_c2", bus_if.bus_stb, 1'b0);
    chk8("lat_oe_c2", bus_if.bus_oe, 8'hFF);
    chk8("lat_data_c2", bus_if.bus_data, 8'h3C);
    @(negedge clk);
    chk1("lat_stb_c3", bus_if.bus_stb, 1'b1);
    chk8("lat_data_c3", bus_if.bus_data, exp_q.pop_front());
    @(negedge clk);
    chk8("lat_data_c4", bus_if.bus_data, 8'h3C);
    @(negedge clk);
    bus_if.bus_ack = 1'b1;
    @(negedge clk);
    chk1("lat_stb_after_ack", bus_if.bus_stb, 1'b0);
    chk8("lat_data_after_ack", bus_if.bus_data, 8'h3C);
    chk8("lat_oe_ack_high", bus_if.bus_oe, 8'hFF);
    bus_if.bus_ack = 1'b0;
    @(negedge clk);
    chk8("lat_oe_after_release", bus_if.bus_oe, 8'h00);
    chk1("lat_busy_done", bus_if.busy, 1'b0);

    // Burst 01..06 against a slow responder
    for (int i = 1; i <= 5; i++) write_byte(8'(i), 1'b1);
    chk1("burst_full_ready", bus_if.wr_ready, 1'b0);
    bus_if.wr_valid = 1'b0;
    respond(3, 2);
    write_byte(8'h06, 1'b1);
    bus_if.wr_valid = 1'b0;
    for (int i = 0; i < 5; i++) respond(3, 2);
    chk8("burst_q_empty", 8'(exp_q.size()), 8'd0);

    // Ack stuck high from reset blocks the transfer until it falls
    bus_if.bus_ack = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    write_byte(8'h11, 1'b1);
    bus_if.wr_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk8("ackhi_oe", bus_if.bus_oe, 8'h00);
    chk1("ackhi_stb", bus_if.bus_stb, 1'b0);
    chk1("ackhi_busy", bus_if.busy, 1'b1);
    bus_if.bus_ack = 1'b0;
    respond(1, 1);

    // Missing ack: byte EE times out and is dropped, 22 follows normally
    write_byte(8'hEE, 1'b0);
    write_byte(8'h22, 1'b0);
    bus_if.wr_valid = 1'b0;
    wait_stb(1'b1, 10, "to_stb_rise");
    chk8("to_data", bus_if.bus_data, 8'hEE);
    repeat (7) @(negedge clk);
    chk1("to_stb_held", bus_if.bus_stb, 1'b1);
    chk1("to_not_yet", bus_if.timeout, 1'b0);
    @(negedge clk);
    chk1("to_pulse", bus_if.timeout, 1'b1);
    chk1("to_stb_low", bus_if.bus_stb, 1'b0);
    chk8("to_oe_low", bus_if.bus_oe, 8'h00);
    @(negedge clk);
    chk1("to_pulse_end", bus_if.timeout, 1'b0);
    exp_q.push_back(8'h22);
    respond(1, 1);

    // Reset in the middle of a strobe drops the byte
    write_byte(8'hA5, 1'b0);
    bus_if.wr_valid = 1'b0;
    wait_stb(1'b1, 10, "mid_stb_rise");
    chk8("mid_data", bus_if.bus_data, 8'hA5);
    rst = 1'b1;
    @(negedge clk);
    chk8("mid_rst_oe", bus_if.bus_oe, 8'h00);
    chk1("mid_rst_stb", bus_if.bus_stb, 1'b0);
    chk1("mid_rst_busy", bus_if.busy, 1'b0);
    chk1("mid_rst_ready", bus_if.wr_ready, 1'b1);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk8("mid_after_oe", bus_if.bus_oe, 8'h00);

`ifdef UIO_TX_PARITY_EN
    // Parity for 07 (odd weight) then 03 (even weight)
    chk1("par_idle", bus_if.bus_par, 1'b0);
    write_byte(8'h07, 1'b1);
    write_byte(8'h03, 1'b1);
    bus_if.wr_valid = 1'b0;
    respond(1, 1);
    respond(1, 1);
`endif

    chk8("final_q_empty", 8'(exp_q.size()), 8'd0);
    chk1("final_busy", bus_if.busy, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
